// File: rtl/seg7_scan_bcd_multi.sv
// Multiplexed common-anode 7-segment driver fed by a serial double-dabble BCD converter.
// A valid/ready handshake loads a binary word; the finished result is swapped atomically into the display shadow.
module seg7_scan_bcd_multi #(
    parameter int          DATA_W      = 16,
    parameter int          NUM_DIGITS  = 8,
    parameter int          SCAN_DIV    = 1000,
    parameter int          SIGNED_MODE = 1,
    parameter logic [6:0]  UNIT_SEG    = 7'b1000110
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  blank_lz,
    output logic                  conv_done,
    output logic [NUM_DIGITS-1:0] dig,
    output logic [6:0]            seg
);

    localparam int NBCD  = NUM_DIGITS - 2;
    localparam int BCD_W = 4 * NBCD;
    localparam int CNT_W = $clog2(DATA_W);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DIV_W = $clog2(SCAN_DIV);

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     mag_q, mag_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
    logic                  ovf_q, ovf_d;
    logic                  sign_q, sign_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BCD_W-1:0]      sh_bcd_q, sh_bcd_d;
    logic                  sh_sign_q, sh_sign_d;
    logic                  sh_ovf_q, sh_ovf_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic [6:0]            seg_q, seg_d;

    logic                  accept;
    logic                  din_neg;
    logic                  tick;
    logic                  any_nz;
    logic [NBCD-1:0]       lead_nz;
    logic [6:0]            glyph;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = SEG_OFF;
        endcase
    endfunction

    // Ready drops combinationally during reset so nothing is accepted on the reset edge.
    assign din_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = din_valid && din_ready;
    assign din_neg   = (SIGNED_MODE != 0) && din[DATA_W-1];

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        sign_d    = sign_q;
        cnt_d     = cnt_q;
        sh_bcd_d  = sh_bcd_q;
        sh_sign_d = sh_sign_q;
        sh_ovf_d  = sh_ovf_q;
        conv_done = 1'b0;

        bcd_adj = bcd_q;
        for (int k = 0; k < NBCD; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sign_d  = din_neg;
                    mag_d   = din_neg ? (DATA_W'(0) - din) : din;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A one leaving the top nibble means the value needs more digits than exist.
                bcd_d = {bcd_adj[BCD_W-2:0], mag_q[DATA_W-1]};
                mag_d = mag_q << 1;
                ovf_d = ovf_q | bcd_adj[BCD_W-1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                sh_bcd_d  = bcd_q;
                sh_sign_d = sign_q;
                sh_ovf_d  = ovf_q;
                conv_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        any_nz  = 1'b0;
        lead_nz = '0;
        for (int k = NBCD - 1; k >= 0; k--) begin
            any_nz     = any_nz | (sh_bcd_q[4*k +: 4] != 4'd0);
            lead_nz[k] = any_nz;
        end

        glyph = SEG_OFF;
        if (idx_q == '0) begin
            glyph = UNIT_SEG;
        end else if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            glyph = sh_sign_q ? SEG_DASH : SEG_OFF;
        end else begin
            for (int k = 0; k < NBCD; k++) begin
                if (idx_q == IDX_W'(k + 1)) begin
                    if (sh_ovf_q) begin
                        glyph = SEG_DASH;
                    end else if (blank_lz && (k != 0) && !lead_nz[k]) begin
                        glyph = SEG_OFF;
                    end else begin
                        glyph = dec7(sh_bcd_q[4*k +: 4]);
                    end
                end
            end
        end
    end

    // dig and seg load together only on the slot tick, so a mid-slot shadow swap never glitches.
    always_comb begin
        tick  = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
        idx_d = idx_q;
        dig_d = dig_q;
        seg_d = seg_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            dig_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = glyph;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mag_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            sign_q    <= 1'b0;
            cnt_q     <= '0;
            sh_bcd_q  <= '0;
            sh_sign_q <= 1'b0;
            sh_ovf_q  <= 1'b0;
            div_q     <= '0;
            idx_q     <= '0;
            dig_q     <= '1;
            seg_q     <= SEG_OFF;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            sign_q    <= sign_d;
            cnt_q     <= cnt_d;
            sh_bcd_q  <= sh_bcd_d;
            sh_sign_q <= sh_sign_d;
            sh_ovf_q  <= sh_ovf_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            dig_q     <= dig_d;
            seg_q     <= seg_d;
        end
    end

    assign dig = dig_q;
    assign seg = seg_q;

endmodule
